key_io_device: RTL and testbench

- Memory-mapped responder for the four push-buttons on the processor's data bus.
- The CPU is the initiator: it issues loads and stores on the same address/data bus that serves data memory.
- This block synchronizes and debounces KEY[3:0] and exposes the result as KDATA.
- It also provides a KCTRL status/control register with Ready, Overrun and interrupt-enable bits. The top level ORs `rdata` into the memory read mux whenever `sel` is high.

---
 rtl/key_io_device.sv | 136 +++++++++++++
 tb/tb_key_io_device.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_io_device.sv
// key_io_device: memory-mapped push-button responder.
// Synchronizes and debounces the four active-low KEY pins and exposes the
// debounced state (KDATA) plus a status/control register (KCTRL) on the CPU bus.
module key_io_device #(
    parameter int unsigned        DBITS           = 32,
    parameter logic [DBITS-1:0]   ADDR_KDATA      = DBITS'(32'hF0000010),
    parameter logic [DBITS-1:0]   ADDR_KCTRL      = DBITS'(32'hF0000110),
    parameter int unsigned        DEBOUNCE_CYCLES = 500000,
    parameter int unsigned        CNT_BITS        = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_pin,
    input  logic [DBITS-1:0] addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wdata,
    output logic [DBITS-1:0] rdata,
    output logic             sel,
    output logic             irq
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES);

    logic [3:0]          sync1;
    logic [3:0]          s;
    logic [3:0]          candidate;
    logic [CNT_BITS-1:0] count;
    logic [3:0]          kdata;
    logic                ready;
    logic                overrun;
    logic                ie;

    logic                ready_next;
    logic                overrun_next;
    logic                ie_next;

    logic                hit_kdata;
    logic                hit_kctrl;
    logic                kdata_rd;
    logic                kctrl_wr;
    logic                change;
    logic                wdata_unused;

    assign hit_kdata = (addr == ADDR_KDATA);
    assign hit_kctrl = (addr == ADDR_KCTRL);
    assign sel       = hit_kdata | hit_kctrl;
    assign kdata_rd  = rd_en & hit_kdata;
    assign kctrl_wr  = wr_en & hit_kctrl;
    assign irq       = ready & ie;

    // Only wdata[8] (IE) and wdata[2] (Overrun clear) carry meaning.
    assign wdata_unused = ^{wdata[DBITS-1:9], wdata[7:3], wdata[1:0]};

    // A change commits once the candidate has been stable for the full window
    // and differs from what is already published.
    assign change = (count == CNT_MAX) && ((~candidate) != kdata);

    // Two-flop synchronizer; idle (released) pins read as 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 4'hF;
            s     <= 4'hF;
        end else begin
            sync1 <= key_pin;
            s     <= sync1;
        end
    end

    // Shared debounce counter: restart on any difference, saturate at the limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            candidate <= 4'hF;
            count     <= '0;
        end else if (s != candidate) begin
            candidate <= s;
            count     <= '0;
        end else if (count < CNT_MAX) begin
            count     <= count + CNT_BITS'(1);
        end
    end

    // Publish debounced key state (1 = pressed).
    always_ff @(posedge clk) begin
        if (!reset) begin
            kdata <= 4'h0;
        end else if (change) begin
            kdata <= ~candidate;
        end
    end

    // KCTRL next state: a read consumes the pending event, an event wins over an Overrun clear.
    always_comb begin
        ready_next   = ready;
        overrun_next = overrun;
        ie_next      = ie;
        if (kctrl_wr) begin
            ie_next = wdata[8];
            if (!wdata[2]) begin
                overrun_next = 1'b0;
            end
        end
        if (change) begin
            if (ready && !kdata_rd) begin
                overrun_next = 1'b1;
            end
            ready_next = 1'b1;
        end else if (kdata_rd) begin
            ready_next = 1'b0;
        end
    end

    // KCTRL state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
            ie      <= 1'b0;
        end else begin
            ready   <= ready_next;
            overrun <= overrun_next;
            ie      <= ie_next;
        end
    end

    // Read mux from current register state; zero when not addressed.
    always_comb begin
        rdata = '0;
        if (hit_kdata) begin
            rdata = DBITS'(kdata);
        end else if (hit_kctrl) begin
            rdata = DBITS'({ie, 5'b0, overrun, 1'b0, ready});
        end
    end

endmodule

// File: tb/tb_key_io_device.sv
// Bench for key_io_device: directed test-plan steps followed by randomized
// pin/bus traffic checked against an event-level reference model.
module tb_key_io_device;

    localparam int unsigned D  = 4;
    localparam logic [31:0] AK = 32'hF0000010;
    localparam logic [31:0] AC = 32'hF0000110;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_pin;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    // Reference model: published keys and KCTRL bits.
    logic [3:0] m_kdata;
    logic       m_ready;
    logic       m_ovr;
    logic       m_ie;
    logic [3:0] m_pin;

    key_io_device #(
        .DBITS(32),
        .ADDR_KDATA(AK),
        .ADDR_KCTRL(AC),
        .DEBOUNCE_CYCLES(D),
        .CNT_BITS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_pin(key_pin),
        .addr(addr),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .wdata(wdata),
        .rdata(rdata),
        .sel(sel),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] kctrl_exp();
        return {23'b0, m_ie, 5'b0, m_ovr, 1'b0, m_ready};
    endfunction

    // Look at a register without a load strobe (no side effect).
    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        addr  = a;
        rd_en = 1'b0;
        wr_en = 1'b0;
        #1;
        v = rdata;
    endtask

    // Hold a pin pattern long enough to commit, then apply the event to the model.
    task automatic settle(input logic [3:0] p);
        key_pin = p;
        m_pin   = p;
        repeat (D + 8) tick();
        if ((~p) != m_kdata) begin
            if (m_ready) m_ovr = 1'b1;
            m_ready = 1'b1;
            m_kdata = ~p;
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] v;
        peek(AK, v);
        check({tag, "_kdata"}, v, {28'b0, m_kdata});
        peek(AC, v);
        check({tag, "_kctrl"}, v, kctrl_exp());
        check({tag, "_irq"}, 32'(irq), 32'(m_ready & m_ie));
    endtask

    // One bus cycle: check combinational outputs, clock it, update the model.
    task automatic bus_op(input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd;
        addr  = a;
        rd_en = r;
        wr_en = w;
        wdata = wd;
        #1;
        exp_rd = (a == AK) ? {28'b0, m_kdata} : (a == AC) ? kctrl_exp() : 32'h0;
        check({tag, "_sel"}, 32'(sel), 32'((a == AK) || (a == AC)));
        check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_irq"}, 32'(irq), 32'(m_ready & m_ie));
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (r && a == AK) m_ready = 1'b0;
        if (w && a == AC) begin
            m_ie = wd[8];
            if (!wd[2]) m_ovr = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          k;
        logic        done;

        reset   = 1'b0;
        key_pin = 4'hF;
        addr    = 32'h0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        wdata   = 32'h0;
        m_kdata = 4'h0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ie    = 1'b0;
        m_pin   = 4'hF;

        // Reset state.
        tick();
        tick();
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        peek(AK, v); check("rst_kdata", v, 32'h0);
        peek(AC, v); check("rst_kctrl", v, 32'h0);

        // Debounced press of KEY0; measure pin-to-update latency.
        key_pin = 4'hE;
        m_pin   = 4'hE;
        k = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            tick();
            k++;
            peek(AK, v);
            if (v == 32'h1) done = 1'b1;
        end
        check("press_latency_in_window", 32'(done && k >= D + 2 && k <= D + 4), 32'h1);
        lat = done ? k : D + 4;
        peek(AC, v); check("press_kctrl", v, 32'h1);
        m_kdata = 4'h1;
        m_ready = 1'b1;

        // Short glitch on KEY1 is filtered.
        key_pin = 4'hD;
        repeat (D - 1) tick();
        key_pin = 4'hE;
        repeat (D + 8) tick();
        peek(AK, v); check("glitch_kdata", v, 32'h1);
        peek(AC, v); check("glitch_kctrl", v, 32'h1);

        // KDATA read clears Ready.
        bus_op(AK, 1'b1, 1'b0, 32'h0, "rdclr");
        peek(AC, v); check("rdclr_kctrl", v, 32'h0);

        // Overrun set, cleared by writing 0, kept by writing 1.
        settle(4'hC);
        peek(AC, v); check("ovr_first_kctrl", v, 32'h1);
        settle(4'hE);
        peek(AC, v); check("ovr_set_kctrl", v, 32'h5);
        bus_op(AC, 1'b0, 1'b1, 32'h0, "ovr_clr");
        peek(AC, v); check("ovr_clr_kctrl", v, 32'h1);
        settle(4'hC);
        peek(AC, v); check("ovr_again_kctrl", v, 32'h5);
        bus_op(AC, 1'b0, 1'b1, 32'h4, "ovr_keep");
        peek(AC, v); check("ovr_keep_kctrl", v, 32'h5);
        bus_op(AK, 1'b0, 1'b1, 32'hFFFF_FFFF, "kdata_wr_ignored");
        peek(AK, v); check("kdata_wr_ignored_val", v, 32'h3);
        bus_op(AC, 1'b0, 1'b1, 32'h0, "ovr_clr2");
        bus_op(AK, 1'b1, 1'b0, 32'h0, "ovr_rd");
        peek(AC, v); check("ovr_final_kctrl", v, 32'h0);

        // Interrupt enable and request.
        settle(4'hF);
        bus_op(AK, 1'b1, 1'b0, 32'h0, "irq_pre_rd");
        bus_op(AC, 1'b0, 1'b1, 32'h100, "irq_ie_wr");
        peek(AC, v); check("irq_ie_kctrl", v, 32'h100);
        check("irq_idle", 32'(irq), 32'h0);
        settle(4'hB);
        check("irq_raised", 32'(irq), 32'h1);
        peek(AC, v); check("irq_kctrl", v, 32'h101);
        bus_op(AK, 1'b1, 1'b0, 32'h0, "irq_rd");
        check("irq_dropped", 32'(irq), 32'h0);

        // KDATA read on the commit edge: Ready ends up set, no Overrun.
        key_pin = 4'hF;
        m_pin   = 4'hF;
        repeat (lat - 1) tick();
        addr  = AK;
        rd_en = 1'b1;
        #1;
        check("col_rd_pre_rdata", rdata, 32'h4);
        tick();
        rd_en = 1'b0;
        peek(AC, v); check("col_rd_kctrl", v, 32'h101);
        peek(AK, v); check("col_rd_kdata", v, 32'h0);

        // Overrun-clear write on an event edge while Ready=1: set wins.
        key_pin = 4'hE;
        m_pin   = 4'hE;
        repeat (lat - 1) tick();
        addr  = AC;
        wr_en = 1'b1;
        wdata = 32'h0;
        #1;
        tick();
        wr_en = 1'b0;
        peek(AC, v); check("col_wr_kctrl", v, 32'h5);
        peek(AK, v); check("col_wr_kdata", v, 32'h1);

        // Reset mid-debounce: held key commits only after a full window.
        key_pin = 4'hD;
        m_pin   = 4'hD;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        peek(AK, v); check("rstmid_kdata", v, 32'h0);
        peek(AC, v); check("rstmid_kctrl", v, 32'h0);
        check("rstmid_irq", 32'(irq), 32'h0);
        repeat (lat - 2) tick();
        peek(AK, v); check("rstmid_not_yet", v, 32'h0);
        repeat (2) tick();
        peek(AK, v); check("rstmid_commit_kdata", v, 32'h2);
        peek(AC, v); check("rstmid_commit_kctrl", v, 32'h1);
        m_kdata = 4'h2;
        m_ready = 1'b1;
        m_ovr   = 1'b0;
        m_ie    = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            int unsigned r;
            logic [31:0] a;
            logic [31:0] wd;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    key_pin = 4'($urandom);
                    repeat ($urandom_range(1, D - 1)) tick();
                    key_pin = m_pin;
                    repeat (D + 8) tick();
                    check_model("rnd_glitch");
                end
                settle(4'($urandom));
                check_model("rnd_settle");
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = AK;
                    1:       a = AC;
                    default: a = $urandom;
                endcase
                wd = $urandom;
                bus_op(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd, "rnd_bus");
            end
        end
        check_model("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
